// File: rtl/lcg_arbiter.sv
// Round-robin arbiter in front of a shared linear congruential generator.
// Each grant delivers one freshly advanced LCG value to the winning requester.
module lcg_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned MULT_A     = 32'd1664525,
  parameter int unsigned INC_C      = 32'd1013904223,
  parameter int unsigned SEED_INIT  = 32'd1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  seed_valid,
  input  logic [DATA_WIDTH-1:0] seed_data,
  output logic                  seed_ready,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rnd_valid,
  output logic [DATA_WIDTH-1:0] rnd_data,
  output logic                  busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [DATA_WIDTH-1:0] L_A    = DATA_WIDTH'(MULT_A);
  localparam logic [DATA_WIDTH-1:0] L_C    = DATA_WIDTH'(INC_C);
  localparam logic [DATA_WIDTH-1:0] L_SEED = DATA_WIDTH'(SEED_INIT);
  localparam logic [IW-1:0]         L_LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_CALC,
    S_DELIVER
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_lcg;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_win;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_found;
  logic [IW-1:0]         w_win;
  logic [IW-1:0]         w_ptr_nxt;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [DATA_WIDTH-1:0] w_lcg_nxt;

  // First requester at or after r_ptr, wrapping to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[IW'((int'(r_ptr) + i) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign w_ptr_nxt = (w_win == L_LAST) ? '0 : w_win + IW'(1);
  assign w_onehot  = NUM_REQ'(1) << r_win;

  // Width-limited multiply keeps exactly the low DATA_WIDTH product bits.
  assign w_lcg_nxt = r_lcg * L_A + L_C;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_lcg   <= L_SEED;
      r_seed  <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_gnt <= '0;
      r_vld <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (seed_valid) begin
            r_seed  <= seed_data;
            r_state <= S_SEED;
          end else if (w_found) begin
            r_win   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_CALC;
          end
        end
        S_SEED: begin
          r_lcg   <= r_seed;
          r_state <= S_IDLE;
        end
        S_CALC: begin
          r_lcg   <= w_lcg_nxt;
          r_data  <= w_lcg_nxt;
          r_gnt   <= w_onehot;
          r_vld   <= 1'b1;
          r_state <= S_DELIVER;
        end
        S_DELIVER: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rnd_valid  = r_vld;
  assign rnd_data   = r_data;
  assign seed_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_lcg_arbiter.sv
// Directed bench for lcg_arbiter: reset, seeding, latency,
// round-robin order, pointer wrap and reset abort.
module tb_lcg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        seed_valid = 1'b0;
  logic [31:0] seed_data = '0;
  logic        seed_ready;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [31:0] rnd_data;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  lcg_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(32),
    .MULT_A(32'd1664525),
    .INC_C(32'd1013904223),
    .SEED_INIT(32'd1)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .seed_valid(seed_valid),
    .seed_data(seed_data),
    .seed_ready(seed_ready),
    .req(req),
    .gnt(gnt),
    .rnd_valid(rnd_valid),
    .rnd_data(rnd_data),
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'd1664525 + 32'd1013904223;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET     = 1'b1;
    seed_valid = 1'b0;
    step();
    step();
    ARESET = 1'b0;
  endtask

  task automatic wait_gnt(input string tag,
                          input logic [3:0] eg,
                          input logic [31:0] ed,
                          output int at);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (gnt == 4'b0 && n < 12);
    at = cyc;
    chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
    chk({tag, "_vld"}, 64'(rnd_valid), 64'd1);
    chk({tag, "_data"}, 64'(rnd_data), 64'(ed));
  endtask

  logic [3:0] ord [5];
  logic [31:0] d;
  int t0, t1, tp;

  initial begin
    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset state
    req = 4'b0000;
    do_reset();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_vld", 64'(rnd_valid), 64'd0);
    chk("rst_data", 64'(rnd_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_srdy", 64'(seed_ready), 64'd1);

    // first grant and its latency
    req = 4'b0001;
    t0 = cyc;
    step();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_srdy", 64'(seed_ready), 64'd0);
    chk("t1_gnt0", 64'(gnt), 64'd0);
    wait_gnt("t1", 4'b0001, 32'h3C88596C, t1);
    chk("t1_lat", 64'(t1 - t0), 64'd2);
    req = 4'b0000;
    step();
    chk("t1_gnt_off", 64'(gnt), 64'd0);
    chk("t1_vld_off", 64'(rnd_valid), 64'd0);
    chk("t1_hold", 64'(rnd_data), 64'h3C88596C);

    // seed 0, then two grants
    do_reset();
    seed_valid = 1'b1;
    seed_data  = 32'h0;
    step();
    seed_valid = 1'b0;
    chk("t2_seed_busy", 64'(busy), 64'd1);
    step();
    req = 4'b0100;
    wait_gnt("t2a", 4'b0100, 32'h3C6EF35F, t1);
    wait_gnt("t2b", 4'b0100, lcg(32'h3C6EF35F), t1);
    req = 4'b0000;

    // all requesting from reset: rotation every 3 cycles
    req = 4'b1111;
    do_reset();
    d  = 32'd1;
    tp = 0;
    for (int k = 0; k < 5; k++) begin
      d = lcg(d);
      wait_gnt($sformatf("t3_%0d", k), ord[k], d, t1);
      if (k > 0) chk($sformatf("t3_gap%0d", k), 64'(t1 - tp), 64'd3);
      tp = t1;
    end
    req = 4'b0000;

    // seed and req together: seed first
    do_reset();
    seed_valid = 1'b1;
    seed_data  = 32'h12345678;
    req        = 4'b0010;
    step();
    seed_valid = 1'b0;
    chk("t4_busy_seed", 64'(busy), 64'd1);
    chk("t4_gnt_seed", 64'(gnt), 64'd0);
    step();
    chk("t4_busy_idle", 64'(busy), 64'd0);
    wait_gnt("t4", 4'b0010, lcg(32'h12345678), t1);
    req = 4'b0000;

    // reset while in CALC
    do_reset();
    req = 4'b0001;
    step();
    chk("t5_calc_busy", 64'(busy), 64'd1);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("t5_gnt", 64'(gnt), 64'd0);
    chk("t5_vld", 64'(rnd_valid), 64'd0);
    chk("t5_data", 64'(rnd_data), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    wait_gnt("t5", 4'b0001, 32'h3C88596C, t1);
    req = 4'b0000;

    // pointer wrap after requester 3
    do_reset();
    d = lcg(32'd1);
    req = 4'b1000;
    wait_gnt("t6a", 4'b1000, d, t1);
    req = 4'b1001;
    d = lcg(d);
    wait_gnt("t6b", 4'b0001, d, t1);
    d = lcg(d);
    wait_gnt("t6c", 4'b1000, d, t1);
    req = 4'b0000;

    // req change after sampling does not move the winner
    do_reset();
    d = lcg(32'd1);
    req = 4'b0001;
    step();
    req = 4'b0010;
    wait_gnt("t7a", 4'b0001, d, t1);
    d = lcg(d);
    wait_gnt("t7b", 4'b0010, d, t1);
    req = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lcg_arbiter.md
LCG_ARBITER -- requirements
Module: lcg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the generator.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of generator state and output.
REQ-003 SHALL have parameter MULT_A, default 1664525: LCG multiplier.
REQ-004 SHALL have parameter INC_C, default 1013904223: LCG increment.
REQ-005 SHALL have parameter SEED_INIT, default 1: generator state loaded at reset.
REQ-006 SHALL have port ACLK  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port ARESET  in  1  reset; synchronous and active-high.
REQ-008 SHALL have port seed_valid  in  1  seed load request.
REQ-009 SHALL have port seed_data  in  DATA_WIDTH  seed value.
REQ-010 SHALL have port seed_ready  out  1  seed accepted when seed_valid and seed_ready are both high.
REQ-011 SHALL have port req  in  NUM_REQ  level-held per-requester number requests.
REQ-012 SHALL have port gnt  out  NUM_REQ  one-hot grant; qualifies rnd_data.
REQ-013 SHALL have port rnd_valid  out  1  high in the cycle gnt is non-zero.
REQ-014 SHALL have port rnd_data  out  DATA_WIDTH  delivered random number.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SEED, CALC, DELIVER.
REQ-017 IDLE: seed_ready high; seed_valid high -> SEED, latch seed_data; else any req bit high -> CALC, latch round-robin winner; else stay IDLE.
REQ-018 Seed precedence: seed_valid and req both high in IDLE -> seed wins; req is evaluated again on return to IDLE.
REQ-019 SEED: state register <= latched seed; next state IDLE; no grant issued.
REQ-020 CALC: state register <= (MULT_A * state + INC_C) mod 2^DATA_WIDTH, computed from the full product truncated to the low DATA_WIDTH bits; next state DELIVER.
REQ-021 DELIVER: gnt = one-hot of latched winner, rnd_valid = 1, rnd_data = updated state, each for exactly one cycle; next state IDLE.
REQ-022 Latency: req sampled in IDLE at edge t -> gnt/rnd_valid visible in the cycle after edge t+1; peak throughput one grant per 3 cycles.
REQ-023 Round-robin: search starts at ptr and proceeds ptr, ptr+1, ... wrapping at NUM_REQ-1 -> 0; ptr <= winner+1 (mod NUM_REQ) on entering CALC.
REQ-024 A requester still holding req after its gnt is treated as a new request; it is served again only after every other pending requester.
REQ-025 seed_ready SHALL be low in SEED, CALC and DELIVER; seed_valid held through those states is accepted on the next IDLE cycle.
REQ-026 req changes outside IDLE SHALL NOT affect the latched winner.
REQ-027 gnt SHALL be 0 and rnd_valid SHALL be 0 in all states except DELIVER.
REQ-028 rnd_data SHALL hold its last delivered value outside DELIVER.

Reset
REQ-029 ARESET high at a rising edge -> state IDLE, generator state = SEED_INIT, ptr = 0, gnt = 0, rnd_valid = 0, rnd_data = 0, busy = 0; seed_ready = 1 from the following cycle.
REQ-030 Reset SHALL take precedence over all other inputs in any state; an in-flight CALC or DELIVER is abandoned with no grant.

Verification
REQ-031 After reset (SEED_INIT=1), req=0001 held -> gnt=0001, rnd_valid=1, rnd_data=0x3C88596C, one cycle, 2 cycles after sampling.
REQ-032 seed_valid=1, seed_data=0 in IDLE, then req=0100 -> gnt=0100, rnd_data=0x3C6EF35F; the next grant yields rnd_data=0x3C88596C + wrap-correct value per REQ-020 (checked against a reference model).
REQ-033 req=1111 held continuously from reset -> grant order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
REQ-034 seed_valid=1 and req=0010 asserted together in IDLE -> seed accepted first, busy=1 for 1 cycle, then gnt=0010 with the value derived from the new seed.
REQ-035 ARESET pulsed while in CALC -> no gnt issued, outputs at reset values on the next cycle, and the next grant returns 0x3C88596C.
REQ-036 ptr wrap: requester 3 served, then req=1001 -> gnt=0001 before 1000.
